// File: rtl/ks_pkg.sv
// Shared constants and state encoding for the keystream XOR block.
package ks_pkg;

    localparam int unsigned KS_W     = 8;
    localparam int unsigned KS_STEPS = 8;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned STEP_W   = $clog2(KS_STEPS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATHER = 2'd1,
        HAVE   = 2'd2
    } ks_state_e;

    function automatic logic even_par(input logic [KS_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ks_gather.sv
// Serial-to-parallel keystream collector: shifts one bit per step, MSB first,
// and flags the step that completes a full byte.
module ks_gather
    import ks_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            step,
    input  logic            ks_bit,
    output logic [KS_W-1:0] ks,
    output logic            done
);

    logic [STEP_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ks    <= '0;
            cnt_q <= '0;
        end else if (clr) begin
            ks    <= '0;
            cnt_q <= '0;
        end else if (step) begin
            ks    <= {ks[KS_W-2:0], ks_bit};
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // The counter wraps to zero on the completing step, ready for the next byte.
    assign done = step && (cnt_q == STEP_W'(KS_STEPS - 1));

endmodule

// File: rtl/keystream_xor.sv
// Keystream XOR cipher: gathers 8 LFSR bits per byte and XORs them onto a
// plaintext stream. Optional even-parity output under `KS_PARITY_EN.
module keystream_xor
    import ks_pkg::*;
(
    input  logic             p_clk_in,
    input  logic             p_rst_n,
    input  logic             p_ks_bit,
    output logic             p_ks_step,
    input  logic             p_clr,
    input  logic             p_in_valid,
    input  logic [KS_W-1:0]  p_in_data,
    output logic             p_in_ready,
    output logic             p_out_valid,
    output logic [KS_W-1:0]  p_out_data,
    input  logic             p_out_ready,
    output logic [CNT_W-1:0] p_bytes
`ifdef KS_PARITY_EN
    ,
    output logic             p_out_par
`endif
);

    ks_state_e        state_q;
    logic             step_q;
    logic             out_valid_q;
    logic [KS_W-1:0]  out_data_q;
    logic [CNT_W-1:0] bytes_q;
    logic [KS_W-1:0]  ks;
    logic             ks_done;
    logic             in_hs;
    logic             out_hs;

    ks_gather u_gather (
        .clk    (p_clk_in),
        .rst_n  (p_rst_n),
        .clr    (p_clr),
        .step   (step_q),
        .ks_bit (p_ks_bit),
        .ks     (ks),
        .done   (ks_done)
    );

    assign p_in_ready = (state_q == HAVE) && (!out_valid_q || p_out_ready);
    assign in_hs      = p_in_valid && p_in_ready;
    assign out_hs     = out_valid_q && p_out_ready;

    always_ff @(posedge p_clk_in or negedge p_rst_n) begin
        if (!p_rst_n) begin
            state_q <= IDLE;
            step_q  <= 1'b0;
        end else if (p_clr) begin
            state_q <= IDLE;
            step_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= GATHER;
                    step_q  <= 1'b1;
                end
                GATHER: begin
                    if (ks_done) begin
                        state_q <= HAVE;
                        step_q  <= 1'b0;
                    end
                end
                HAVE: begin
                    if (in_hs) begin
                        state_q <= GATHER;
                        step_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    step_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output register and transfer counter; clear suppresses any handshake in the same cycle.
    always_ff @(posedge p_clk_in or negedge p_rst_n) begin
        if (!p_rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            bytes_q     <= '0;
        end else if (p_clr) begin
            out_valid_q <= 1'b0;
            bytes_q     <= '0;
        end else begin
            if (out_hs) begin
                bytes_q <= bytes_q + 1'b1;
            end
            if (in_hs) begin
                out_data_q  <= p_in_data ^ ks;
                out_valid_q <= 1'b1;
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign p_ks_step   = step_q;
    assign p_out_valid = out_valid_q;
    assign p_out_data  = out_data_q;
    assign p_bytes     = bytes_q;

`ifdef KS_PARITY_EN
    logic par_q;

    always_ff @(posedge p_clk_in or negedge p_rst_n) begin
        if (!p_rst_n) begin
            par_q <= 1'b0;
        end else if (!p_clr && in_hs) begin
            par_q <= even_par(p_in_data ^ ks);
        end
    end

    assign p_out_par = par_q;
`endif

endmodule

// File: tb/tb_keystream_xor.sv
// Self-checking bench for keystream_xor against a byte-level reference model.
module tb_keystream_xor;

    logic        p_clk_in = 1'b0;
    logic        p_rst_n;
    logic        p_ks_bit;
    logic        p_ks_step;
    logic        p_clr;
    logic        p_in_valid;
    logic [7:0]  p_in_data;
    logic        p_in_ready;
    logic        p_out_valid;
    logic [7:0]  p_out_data;
    logic        p_out_ready;
    logic [15:0] p_bytes;
`ifdef KS_PARITY_EN
    logic        p_out_par;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          ks_mode  = 0;
    bit          idle_m;
    bit          win[$];
    logic [7:0]  exp_q[$];
    logic [15:0] bytes_m;

    keystream_xor dut (
        .p_clk_in    (p_clk_in),
        .p_rst_n     (p_rst_n),
        .p_ks_bit    (p_ks_bit),
        .p_ks_step   (p_ks_step),
        .p_clr       (p_clr),
        .p_in_valid  (p_in_valid),
        .p_in_data   (p_in_data),
        .p_in_ready  (p_in_ready),
        .p_out_valid (p_out_valid),
        .p_out_data  (p_out_data),
        .p_out_ready (p_out_ready),
        .p_bytes     (p_bytes)
`ifdef KS_PARITY_EN
        ,
        .p_out_par   (p_out_par)
`endif
    );

    always #5 p_clk_in = ~p_clk_in;

    // Keystream source: mode 1 alternates starting at 1, mode 2 is all ones, else random.
    function automatic logic next_bit(input logic cur);
        case (ks_mode)
            1:       return ~cur;
            2:       return 1'b1;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // The first consumed bit carries weight 128, the eighth weight 1.
    function automatic logic [7:0] ks_byte();
        int unsigned v = 0;
        for (int i = 0; i < win.size(); i++)
            v = v + (int'(win[i]) << (7 - i));
        return 8'(v);
    endfunction

    // Advances one clock, updates the model from the handshakes seen before the edge,
    // then compares every output against it.
    task automatic tick();
        logic step, in_hs, out_hs, clr;
        logic [7:0] ct;
        bit exp_step, exp_rdy;
        step   = p_ks_step;
        clr    = p_clr;
        in_hs  = p_in_valid && p_in_ready;
        out_hs = p_out_valid && p_out_ready;
        if (clr) begin
            win.delete();
            exp_q.delete();
            bytes_m = '0;
        end else begin
            if (out_hs && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                bytes_m = bytes_m + 16'd1;
            end
            if (in_hs) begin
                n_checks++;
                if (win.size() !== 8) begin
                    n_fail++;
                    $display("FAIL ks_bits_per_byte: consumed %0d required 8", win.size());
                end
                ct = p_in_data ^ ks_byte();
                exp_q.push_back(ct);
                win.delete();
            end
            if (step) win.push_back(p_ks_bit);
        end
        @(posedge p_clk_in);
        #1;
        idle_m = clr;
        if (step) p_ks_bit = next_bit(p_ks_bit);

        n_checks++;
        if (p_bytes !== bytes_m) begin
            n_fail++;
            $display("FAIL bytes: got %h required %h", p_bytes, bytes_m);
        end
        n_checks++;
        if (p_out_valid !== (exp_q.size() > 0)) begin
            n_fail++;
            $display("FAIL out_valid: got %b required %b", p_out_valid, exp_q.size() > 0);
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            if (p_out_data !== exp_q[0]) begin
                n_fail++;
                $display("FAIL out_data: got %h required %h", p_out_data, exp_q[0]);
            end
`ifdef KS_PARITY_EN
            n_checks++;
            if (p_out_par !== ^exp_q[0]) begin
                n_fail++;
                $display("FAIL out_par: got %b required %b", p_out_par, ^exp_q[0]);
            end
`endif
        end
        exp_step = !idle_m && (win.size() < 8);
        n_checks++;
        if (p_ks_step !== exp_step) begin
            n_fail++;
            $display("FAIL ks_step: got %b required %b", p_ks_step, exp_step);
        end
        exp_rdy = (win.size() == 8) && (exp_q.size() == 0 || p_out_ready);
        n_checks++;
        if (p_in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL in_ready: got %b required %b", p_in_ready, exp_rdy);
        end
    endtask

    task automatic model_reset();
        win.delete();
        exp_q.delete();
        bytes_m = '0;
        idle_m  = 1'b1;
    endtask

    task automatic do_reset(input int mode);
        ks_mode     = mode;
        p_rst_n     = 1'b0;
        p_clr       = 1'b0;
        p_in_valid  = 1'b0;
        p_in_data   = '0;
        p_out_ready = 1'b0;
        p_ks_bit    = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge p_clk_in);
        #1;
        p_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_ready(output int steps);
        steps = 0;
        for (int i = 0; i < 40 && !p_in_ready; i++) begin
            if (p_ks_step) steps++;
            tick();
        end
        n_checks++;
        if (p_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_ready: in_ready %b required 1 within 40 cycles", p_in_ready);
        end
    endtask

    task automatic send(input logic [7:0] d);
        p_in_valid = 1'b1;
        p_in_data  = d;
        tick();
        p_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        p_rst_n = 1'b0;
        p_clr = 1'b0; p_in_valid = 1'b0; p_in_data = '0; p_out_ready = 1'b1; p_ks_bit = 1'b1;
        #12;
        n_checks++;
        if ({p_ks_step, p_in_ready, p_out_valid, p_out_data, p_bytes} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: step=%b rdy=%b vld=%b data=%h bytes=%h required all 0",
                     p_ks_step, p_in_ready, p_out_valid, p_out_data, p_bytes);
        end
`ifdef KS_PARITY_EN
        n_checks++;
        if (p_out_par !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_par: got %b required 0", p_out_par);
        end
`endif
    endtask

    task automatic test_pattern();
        int steps;
        do_reset(1);
        p_out_ready = 1'b1;
        wait_ready(steps);
        send(8'h55);
        n_checks++;
        if (p_out_data !== 8'hFF) begin
            n_fail++;
            $display("FAIL pattern_data: got %h required ff", p_out_data);
        end
`ifdef KS_PARITY_EN
        n_checks++;
        if (p_out_par !== 1'b0) begin
            n_fail++;
            $display("FAIL pattern_par: got %b required 0", p_out_par);
        end
`endif
        tick();
        n_checks++;
        if (p_bytes !== 16'd1) begin
            n_fail++;
            $display("FAIL pattern_bytes: got %h required 0001", p_bytes);
        end
    endtask

    task automatic test_ones();
        int steps;
        do_reset(2);
        p_out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            wait_ready(steps);
            n_checks++;
            if (steps !== 8) begin
                n_fail++;
                $display("FAIL ones_steps: got %0d required 8", steps);
            end
            send(8'h0F);
            n_checks++;
            if (p_out_data !== 8'hF0) begin
                n_fail++;
                $display("FAIL ones_data: got %h required f0", p_out_data);
            end
        end
    endtask

    task automatic test_backpressure();
        int steps;
        logic [7:0] d, held;
        do_reset(0);
        wait_ready(steps);
        d = 8'($urandom);
        send(d);
        held = p_out_data;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (p_out_data !== held) begin
                n_fail++;
                $display("FAIL hold_data: got %h required %h", p_out_data, held);
            end
            if (i >= 8) begin
                n_checks++;
                if (p_in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hold_ready: got %b required 0", p_in_ready);
                end
            end
        end
        p_out_ready = 1'b1;
        tick();
        n_checks++;
        if (p_bytes !== 16'd1 || p_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: bytes=%h vld=%b required 0001 and 0", p_bytes, p_out_valid);
        end
    endtask

    task automatic test_reset_mid_gather();
        int steps;
        do_reset(0);
        p_out_ready = 1'b1;
        wait_ready(steps);
        send(8'($urandom));
        for (int i = 0; i < 4; i++) tick();
        #2;
        p_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({p_ks_step, p_in_ready, p_out_valid, p_out_data, p_bytes} !== 27'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: step=%b rdy=%b vld=%b data=%h bytes=%h required all 0",
                     p_ks_step, p_in_ready, p_out_valid, p_out_data, p_bytes);
        end
        @(posedge p_clk_in);
        #1;
        p_rst_n = 1'b1;
        model_reset();
        n_checks++;
        if (p_ks_step !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_idle: ks_step %b required 0", p_ks_step);
        end
        wait_ready(steps);
        n_checks++;
        if (steps !== 8) begin
            n_fail++;
            $display("FAIL midreset_steps: got %0d required 8", steps);
        end
        send(8'($urandom));
        tick();
    endtask

    task automatic test_clr_handshake();
        int steps;
        do_reset(0);
        p_out_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            wait_ready(steps);
            send(8'($urandom));
        end
        p_clr = 1'b1;
        tick();
        p_clr = 1'b0;
        n_checks++;
        if (p_bytes !== 16'd0 || p_out_valid !== 1'b0 || p_ks_step !== 1'b0 || p_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_wins: bytes=%h vld=%b step=%b rdy=%b required 0000 0 0 0",
                     p_bytes, p_out_valid, p_ks_step, p_in_ready);
        end
        tick();
        n_checks++;
        if (p_ks_step !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_regather: ks_step %b required 1", p_ks_step);
        end
    endtask

    task automatic test_random();
        do_reset(0);
        for (int i = 0; i < 1500; i++) begin
            p_in_valid  = 1'($urandom_range(0, 1));
            p_in_data   = 8'($urandom);
            p_out_ready = ($urandom_range(0, 3) != 0);
            p_clr       = ($urandom_range(0, 59) == 0);
            tick();
        end
        p_clr      = 1'b0;
        p_in_valid = 1'b0;
    endtask

    task automatic test_wrap();
        int steps;
        do_reset(0);
        p_out_ready = 1'b1;
        force dut.bytes_q = 16'hFFFF;
        #1;
        release dut.bytes_q;
        bytes_m = 16'hFFFF;
        wait_ready(steps);
        send(8'($urandom));
        tick();
        n_checks++;
        if (p_bytes !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap: got %h required 0000", p_bytes);
        end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_ones();
        test_backpressure();
        test_reset_mid_gather();
        test_clr_handshake();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
